regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wen/aw/d) between two writeback requesters: req0 = ALU pipe, req1 = load/store unit.
- Uses round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so the decode stage can stall on RAW hazards.
- Sits between the execute/memory stages and the 32x32 register file.

Parameters:
- BITS, 32, data width of a writeback value.
- WORD_DEPTH, 32, number of architectural registers.
- ADDR_WIDTH, 5, register address width; 2^ADDR_WIDTH >= WORD_DEPTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  ADDR_WIDTH  ALU destination register.
- req0_data  in  BITS  ALU result.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, for the LSU.
- issue_valid  in  1  decode dispatches an instruction that writes rd.
- issue_rd  in  ADDR_WIDTH  destination of the dispatched instruction.
- flush  in  1  pipeline flush; clears the scoreboard.
- rs1  in  ADDR_WIDTH  source register query 1.
- rs2  in  ADDR_WIDTH  source register query 2.
- busy1  out  1  write pending to rs1.
- busy2  out  1  write pending to rs2.
- wen  out  1  register-file write enable.
- aw  out  ADDR_WIDTH  register-file write address.
- d  out  BITS  register-file write data.

Behaviour:
- Reset (async, reset_n=0):
  - wen=0, aw=0, d=0.
  - All busy bits cleared.
  - Round-robin pointer last=1, so req0 wins the first contention.
- Arbitration (combinational ready):
  - req0_ready = req0_valid & (!req1_valid | last==1).
  - req1_ready = req1_valid & (!req0_valid | last==0).
  - At most one ready per cycle.
  - The pointer `last` updates to the granted index on every grant; it holds when there is no grant.
- Handshake: a transfer occurs when valid & ready. Requesters hold valid/addr/data stable until ready; no back-to-back limit.
- Write output (registered, latency 1):
  - Transfer in cycle N gives, in cycle N+1: wen=1, aw=addr, d=data.
  - With no transfer in cycle N: wen=0 in cycle N+1; aw/d hold their previous values.
- x0 handling:
  - A transfer with addr==0 is still handshaken (ready as normal), but wen stays 0 the next cycle.
  - busy bit 0 is constant 0.
  - issue_rd==0 is ignored.
- Scoreboard:
  - busy[issue_rd] is set at the edge where issue_valid=1.
  - busy[aw] is cleared at the edge where wen=1, i.e. the same edge the register file latches d. The bit reads 0 from cycle N+2 on, which is exactly when the register file holds the new value.
  - Simultaneous set and clear of the same register: set wins, since the new producer is outstanding.
- Flush:
  - Clears all busy bits at the edge; takes priority over issue in the same cycle.
  - Does not cancel a write already registered on wen/aw/d.
  - Does not affect the handshakes.
- Queries: busy1=busy[rs1], busy2=busy[rs2], both combinational; rs==0 gives 0.
- Reset mid-operation: a pending accepted write is discarded (wen=0); all scoreboard state is lost.

Decomposition:
- Shared package holds:
  - BITS/WORD_DEPTH/ADDR_WIDTH defaults.
  - REQ_ALU=0 and REQ_LSU=1 requester-index constants.
  - A writeback-request typedef {valid, addr, data}.
- One natural sub-module: regfile_scoreboard (busy vector, set/clear/flush, two query ports).
- The arbiter and output register stay in the top module.

Test Plan:
- Reset, then only req0 valid (addr=5, data=0xDEADBEEF) in cycle 1 -> req0_ready=1 in cycle 1; cycle 2 wen=1, aw=5, d=0xDEADBEEF; cycle 3 wen=0.
- Both valid every cycle (req0 addr=1/data=0x11, req1 addr=2/data=0x22), held stable until accepted -> grants alternate 0,1,0,1; the wen stream reads aw=1,2,1,2 with no idle cycles.
- issue_valid with issue_rd=7 at cycle 1 -> busy1=1 with rs1=7 from cycle 2; req1 writes addr=7 at cycle 3 -> wen in cycle 4; busy1=0 from cycle 5.
- Same-register collision: wen with aw=7 and issue_valid with issue_rd=7 in the same cycle -> busy[7] remains 1.
- req0 addr=0, data=0x1234 -> req0_ready=1, wen stays 0; busy with rs1=0 is always 0; issue_rd=0 sets nothing.
- busy[3] and busy[9] set, then flush together with issue_rd=4 -> all busy bits 0 next cycle. Then reset_n pulsed low mid-transfer -> wen, aw and d drop to 0 asynchronously.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
// Holds the default widths, the requester indices and the writeback-request type.
package regfile_wb_arbiter_pkg;

    localparam int DEF_BITS       = 32;
    localparam int DEF_WORD_DEPTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_BITS-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on issue,
// cleared when the register file latches the write, wiped on flush.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WORD_DEPTH = DEF_WORD_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2
);

    logic [WORD_DEPTH-1:0] r_busy;
    logic [WORD_DEPTH-1:0] w_busy_nxt;

    // Set is applied after clear so a new producer to the same register stays outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < WORD_DEPTH; i++) begin
            if (clr_en && (clr_addr == i[ADDR_WIDTH-1:0])) w_busy_nxt[i] = 1'b0;
            if (set_en && (set_addr == i[ADDR_WIDTH-1:0])) w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
        if (flush) w_busy_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_busy <= '0;
        else          r_busy <= w_busy_nxt;
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 1; i < WORD_DEPTH; i++) begin
            if (rs1 == i[ADDR_WIDTH-1:0]) busy1 = r_busy[i];
            if (rs2 == i[ADDR_WIDTH-1:0]) busy2 = r_busy[i];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and LSU,
// with a registered write port and a RAW-hazard scoreboard for decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int BITS       = DEF_BITS,
    parameter int WORD_DEPTH = DEF_WORD_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [BITS-1:0]       req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [BITS-1:0]       req1_data,
    output logic                  req1_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] aw,
    output logic [BITS-1:0]       d
);

    logic                  r_last;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_aw;
    logic [BITS-1:0]       r_d;

    wb_req_t w_req0;
    wb_req_t w_req1;
    wb_req_t w_win;
    logic    w_xfer;

    assign w_req0 = {req0_valid, req0_addr, req0_data};
    assign w_req1 = {req1_valid, req1_addr, req1_data};

    assign req0_ready = req0_valid & (~req1_valid | (r_last == REQ_LSU));
    assign req1_ready = req1_valid & (~req0_valid | (r_last == REQ_ALU));
    assign w_xfer     = req0_ready | req1_ready;
    assign w_win      = req1_ready ? w_req1 : w_req0;

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= REQ_LSU;
            r_wen  <= 1'b0;
            r_aw   <= '0;
            r_d    <= '0;
        end else if (w_xfer) begin
            r_last <= req1_ready ? REQ_LSU : REQ_ALU;
            r_wen  <= w_win.valid & (w_win.addr != '0);
            r_aw   <= w_win.addr;
            r_d    <= w_win.data;
        end else begin
            r_wen  <= 1'b0;
        end
    end

    assign wen = r_wen;
    assign aw  = r_aw;
    assign d   = r_d;

    regfile_scoreboard #(
        .WORD_DEPTH (WORD_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (issue_valid),
        .set_addr (issue_rd),
        .clr_en   (r_wen),
        .clr_addr (r_aw),
        .flush    (flush),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule
